// File: rtl/ahb_apb_bridge_ctrl_if.sv
// ahb_apb_bridge_ctrl_if
// Bundles the AHB slave-side and APB master-side signals of the bridge core.
//   slave  modport : the bridge's view (it is the AHB slave and drives the APB bus)
//   master modport : the environment's view (AHB master plus APB peripherals)
// AHB: htrans, hwrite, hready_in, hsize, haddr, hwdata -> bridge; hrdata, hresp, hready_out <- bridge
// APB: paddr, pwdata, pwrite, psel, penable <- bridge; prdata, pready -> bridge
interface ahb_apb_bridge_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3
);
    logic [1:0]         htrans;
    logic               hwrite;
    logic               hready_in;
    logic [2:0]         hsize;
    logic [ADDR_W-1:0]  haddr;
    logic [DATA_W-1:0]  hwdata;
    logic [DATA_W-1:0]  hrdata;
    logic [1:0]         hresp;
    logic               hready_out;

    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata;
    logic               pwrite;
    logic [NUM_SLV-1:0] psel;
    logic               penable;
    logic [DATA_W-1:0]  prdata;
    logic               pready;

    modport slave (
        input  htrans, hwrite, hready_in, hsize, haddr, hwdata, prdata, pready,
        output hrdata, hresp, hready_out, paddr, pwdata, pwrite, psel, penable
    );

    modport master (
        output htrans, hwrite, hready_in, hsize, haddr, hwdata, prdata, pready,
        input  hrdata, hresp, hready_out, paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/ahb_apb_bridge_ctrl.sv
// ahb_apb_bridge_ctrl
// Bridge core: takes single AHB transfers, decodes the address onto one of
// NUM_SLV APB slaves and sequences APB SETUP/ENABLE, stalling AHB via hready_out.
// Ports:
//   clock    system clock, posedge
//   hresetn  asynchronous active-low reset
//   bus      ahb_apb_bridge_ctrl_if.slave (AHB slave side + APB master side)
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | no transfer in flight; ready to sample an address phase
// S_RD_SETUP  | APB read SETUP (psel up, penable low)
// S_RD_ENABLE | APB read ENABLE; waits for pready, hrdata = prdata
// S_WR_WAIT   | AHB write data phase; hwdata captured into pwdata
// S_WR_SETUP  | APB write SETUP
// S_WR_ENABLE | APB write ENABLE; waits for pready
module ahb_apb_bridge_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                NUM_SLV  = 3,
    parameter logic [ADDR_W-1:0] S0_BASE  = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0400_0000
) (
    input  logic                 clock,
    input  logic                 hresetn,
    ahb_apb_bridge_ctrl_if.slave bus
);
    localparam int SZ_LOG2 = $clog2(SLV_SIZE);
    localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [NUM_SLV-1:0] SEL_ONE = NUM_SLV'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_ENABLE,
        S_WR_WAIT,
        S_WR_SETUP,
        S_WR_ENABLE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_SLV-1:0] psel_q;
    logic               penable_q;
    logic               pwrite_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic [DATA_W-1:0]  pwdata_q;

    logic [ADDR_W-1:0]  offset;
    logic [ADDR_W-1:0]  slot;
    logic [IDX_W-1:0]   idx_d;
    logic               in_range;
    logic               valid;
    logic               in_enable;
    logic               hready;
    logic               unused_hsize;

    // SLV_SIZE is a power of two, so the slot number is a plain shift
    assign offset    = bus.haddr - S0_BASE;
    assign slot      = offset >> SZ_LOG2;
    assign in_range  = (bus.haddr >= S0_BASE) && (slot < ADDR_W'(NUM_SLV));
    assign idx_d     = slot[IDX_W-1:0];
    assign valid     = bus.hready_in && bus.htrans[1] && in_range;
    assign in_enable = (state_q == S_RD_ENABLE) || (state_q == S_WR_ENABLE);
    assign hready    = (state_q == S_IDLE) || (in_enable && bus.pready);

    assign bus.hready_out = hready;
    assign bus.hrdata     = bus.prdata;
    assign bus.hresp      = 2'b00;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;

    assign unused_hsize = ^bus.hsize;

    always_ff @(posedge clock or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            case (state_q)
                // IDLE and a completing ENABLE share the address-phase sampling,
                // which is what gives back-to-back transfers without a gap
                S_IDLE, S_RD_ENABLE, S_WR_ENABLE: begin
                    if (hready) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        state_q   <= S_IDLE;
                        if (valid) begin
                            idx_q    <= idx_d;
                            paddr_q  <= bus.haddr;
                            pwrite_q <= bus.hwrite;
                            if (bus.hwrite) begin
                                state_q <= S_WR_WAIT;
                            end else begin
                                state_q <= S_RD_SETUP;
                                psel_q  <= SEL_ONE << idx_d;
                            end
                        end
                    end
                end
                S_WR_WAIT: begin
                    pwdata_q <= bus.hwdata;
                    psel_q   <= SEL_ONE << idx_q;
                    state_q  <= S_WR_SETUP;
                end
                S_RD_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_RD_ENABLE;
                end
                S_WR_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_WR_ENABLE;
                end
                default: begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Directed bench for ahb_apb_bridge_ctrl. A transfer-level planner turns a list
// of AHB transfers into per-cycle stimulus and expected outputs from the timing
// rules; a single runner drives and compares every cycle. Literal checks on the
// recorded outputs pin key values independently of the planner.
module tb_ahb_apb_bridge_ctrl;
    localparam int N = 64;
    localparam longint unsigned S0 = 64'h8000_0000;
    localparam longint unsigned SZ = 64'h0400_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_apb_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bus ();

    ahb_apb_bridge_ctrl dut (
        .clock   (clk),
        .hresetn (rst_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [1:0]  in_htrans [N];
    logic        in_hwrite [N];
    logic        in_hrdyin [N];
    logic [31:0] in_haddr  [N];
    logic [31:0] in_hwdata [N];
    logic [31:0] in_prdata [N];
    logic        in_pready [N];

    logic [2:0]  ex_psel   [N];
    logic        ex_pen    [N];
    logic        ex_pwrite [N];
    logic        ex_hready [N];
    logic [31:0] ex_paddr  [N];
    logic [31:0] ex_pwdata [N];
    logic [31:0] ex_hrdata [N];
    logic        ex_chk_rd [N];

    logic [2:0]  ob_psel   [N];
    logic        ob_pen    [N];
    logic        ob_hready [N];
    logic [31:0] ob_pwdata [N];
    logic [31:0] ob_hrdata [N];

    int cur;
    int plan_len;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    function automatic void plan_clear();
        for (int i = 0; i < N; i++) begin
            in_htrans[i] = 2'b00; in_hwrite[i] = 1'b0; in_hrdyin[i] = 1'b1;
            in_haddr[i]  = '0;    in_hwdata[i] = '0;   in_prdata[i] = '0;
            in_pready[i] = 1'b1;
            ex_psel[i] = 3'b000; ex_pen[i] = 1'b0; ex_pwrite[i] = 1'b0; ex_hready[i] = 1'b1;
            ex_paddr[i] = '0; ex_pwdata[i] = '0; ex_hrdata[i] = '0; ex_chk_rd[i] = 1'b0;
        end
        cur = 0;
        plan_len = 0;
    endfunction

    // One AHB transfer presented at the current cycle; gap = idle cycles after
    // completion before the next address phase (0 = back-to-back).
    function automatic void plan_xfer(input logic [1:0] tr, input logic rdy, input logic wr,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [31:0] rd, input int waits, input int gap);
        int t0 = cur;
        int e;
        int c;
        int s;
        longint unsigned a64 = 64'(a);
        bit v;
        in_htrans[t0] = tr; in_hwrite[t0] = wr; in_haddr[t0] = a; in_hrdyin[t0] = rdy;
        v = rdy && tr[1] && (a64 >= S0) && ((a64 - S0) / SZ < 3);
        if (!v) begin
            cur = t0 + 1 + gap;
        end else begin
            s = int'((a64 - S0) / SZ);
            e = t0 + 1;
            if (wr) begin
                in_hwdata[t0+1] = wd;
                ex_hready[t0+1] = 1'b0;
                e = t0 + 2;
            end
            ex_psel[e] = 3'(1 << s); ex_pen[e] = 1'b0; ex_pwrite[e] = wr;
            ex_paddr[e] = a; ex_pwdata[e] = wd; ex_hready[e] = 1'b0;
            for (int k = 0; k <= waits; k++) begin
                c = e + 1 + k;
                ex_psel[c] = 3'(1 << s); ex_pen[c] = 1'b1; ex_pwrite[c] = wr;
                ex_paddr[c] = a; ex_pwdata[c] = wd;
                in_pready[c] = (k == waits);
                ex_hready[c] = (k == waits);
                if (!wr && k == waits) begin
                    in_prdata[c] = rd; ex_hrdata[c] = rd; ex_chk_rd[c] = 1'b1;
                end else begin
                    in_prdata[c] = ~rd;
                end
            end
            cur = e + 1 + waits + gap;
        end
        if (cur + 3 > plan_len) plan_len = cur + 3;
    endfunction

    task automatic run_plan(input int upto);
        for (int c = 0; c < upto; c++) begin
            @(posedge clk); #1;
            bus.htrans = in_htrans[c]; bus.hwrite = in_hwrite[c]; bus.hready_in = in_hrdyin[c];
            bus.haddr = in_haddr[c]; bus.hwdata = in_hwdata[c]; bus.prdata = in_prdata[c];
            bus.pready = in_pready[c]; bus.hsize = 3'b010;
            @(negedge clk);
            ob_psel[c] = bus.psel; ob_pen[c] = bus.penable; ob_hready[c] = bus.hready_out;
            ob_pwdata[c] = bus.pwdata; ob_hrdata[c] = bus.hrdata;
            chk("hready_out", c, 32'(bus.hready_out), 32'(ex_hready[c]));
            chk("psel", c, 32'(bus.psel), 32'(ex_psel[c]));
            chk("penable", c, 32'(bus.penable), 32'(ex_pen[c]));
            chk("hresp", c, 32'(bus.hresp), 32'd0);
            chk("psel_onehot0", c, 32'($onehot0(bus.psel)), 32'd1);
            chk("penable_implies_psel", c, 32'(!(bus.penable && bus.psel == 3'b000)), 32'd1);
            if (ex_psel[c] != 3'b000) begin
                chk("paddr", c, bus.paddr, ex_paddr[c]);
                chk("pwrite", c, 32'(bus.pwrite), 32'(ex_pwrite[c]));
                if (ex_pwrite[c]) chk("pwdata", c, bus.pwdata, ex_pwdata[c]);
            end
            if (ex_chk_rd[c]) chk("hrdata", c, bus.hrdata, ex_hrdata[c]);
        end
    endtask

    initial begin
        bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hready_in = 1'b1; bus.hsize = 3'b010;
        bus.haddr = '0; bus.hwdata = '0; bus.prdata = '0; bus.pready = 1'b1;
        #2;
        chk("rst_psel", 0, 32'(bus.psel), 32'd0);
        chk("rst_penable", 0, 32'(bus.penable), 32'd0);
        chk("rst_pwrite", 0, 32'(bus.pwrite), 32'd0);
        chk("rst_paddr", 0, bus.paddr, 32'd0);
        chk("rst_pwdata", 0, bus.pwdata, 32'd0);
        chk("rst_hready", 0, 32'(bus.hready_out), 32'd1);
        chk("rst_hresp", 0, 32'(bus.hresp), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // single write
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, 2);
        run_plan(plan_len);
        chk("lit_wr_hready_T1", 1, 32'(ob_hready[1]), 32'd0);
        chk("lit_wr_psel_T1", 1, 32'(ob_psel[1]), 32'd0);
        chk("lit_wr_psel_T2", 2, 32'(ob_psel[2]), 32'b001);
        chk("lit_wr_hready_T2", 2, 32'(ob_hready[2]), 32'd0);
        chk("lit_wr_penable_T3", 3, 32'(ob_pen[3]), 32'd1);
        chk("lit_wr_hready_T3", 3, 32'(ob_hready[3]), 32'd1);
        chk("lit_wr_pwdata_T3", 3, ob_pwdata[3], 32'hDEAD_BEEF);

        // single read
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h8400_0004, 32'h0, 32'h1234_5678, 0, 2);
        run_plan(plan_len);
        chk("lit_rd_psel_T1", 1, 32'(ob_psel[1]), 32'b010);
        chk("lit_rd_hrdata_T2", 2, ob_hrdata[2], 32'h1234_5678);
        chk("lit_rd_hready_T2", 2, 32'(ob_hready[2]), 32'd1);

        // wait states
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h8800_0000, 32'h0, 32'hA5A5_0001, 3, 2);
        run_plan(plan_len);
        for (int c = 2; c <= 5; c++) chk("lit_ws_penable", c, 32'(ob_pen[c]), 32'd1);
        chk("lit_ws_psel", 3, 32'(ob_psel[3]), 32'b100);
        chk("lit_ws_hready_low", 4, 32'(ob_hready[4]), 32'd0);
        chk("lit_ws_hready_done", 5, 32'(ob_hready[5]), 32'd1);
        chk("lit_ws_penable_off", 6, 32'(ob_pen[6]), 32'd0);

        // back-to-back write then read, same slave
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 32'h0, 0, 0);
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 32'h7777_8888, 0, 2);
        run_plan(plan_len);
        chk("lit_b2b_psel_wr_en", 3, 32'(ob_psel[3]), 32'b001);
        chk("lit_b2b_psel_rd_setup", 4, 32'(ob_psel[4]), 32'b001);
        chk("lit_b2b_penable_rd_setup", 4, 32'(ob_pen[4]), 32'd0);
        chk("lit_b2b_hrdata", 5, ob_hrdata[5], 32'h7777_8888);

        // mixed back-to-back chain with waits
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h8400_0008, 32'h0, 32'h1111_2222, 1, 0);
        plan_xfer(2'b11, 1'b1, 1'b1, 32'h8800_0004, 32'h3333_4444, 32'h0, 2, 0);
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h5555_6666, 0, 1);
        plan_xfer(2'b10, 1'b1, 1'b1, 32'h8BFF_FFFC, 32'h9999_AAAA, 32'h0, 0, 1);
        run_plan(plan_len);
        chk("lit_mix_wrwait_psel", 4, 32'(ob_psel[4]), 32'd0);
        chk("lit_mix_wrsetup_psel", 5, 32'(ob_psel[5]), 32'b100);

        // ignored transfers and decode boundaries
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h9000_0000, 32'h0, 32'h0, 0, 0);
        plan_xfer(2'b00, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        plan_xfer(2'b01, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0, 0, 0);
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h8C00_0000, 32'h0, 32'h0, 0, 0);
        plan_xfer(2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        plan_xfer(2'b11, 1'b1, 1'b0, 32'h8BFF_FFFC, 32'h0, 32'hCDEF_0123, 0, 2);
        run_plan(plan_len);
        for (int c = 0; c <= 6; c++) chk("lit_ign_psel", c, 32'(ob_psel[c]), 32'd0);
        chk("lit_ign_hready", 2, 32'(ob_hready[2]), 32'd1);
        chk("lit_edge_psel", 7, 32'(ob_psel[7]), 32'b100);

        // reset in the middle of a write ENABLE with pready low
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 5, 0);
        run_plan(5);
        chk("lit_pre_rst_penable", 4, 32'(ob_pen[4]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_psel", 0, 32'(bus.psel), 32'd0);
        chk("midrst_penable", 0, 32'(bus.penable), 32'd0);
        chk("midrst_pwrite", 0, 32'(bus.pwrite), 32'd0);
        chk("midrst_paddr", 0, bus.paddr, 32'd0);
        chk("midrst_pwdata", 0, bus.pwdata, 32'd0);
        chk("midrst_hready", 0, 32'(bus.hready_out), 32'd1);
        @(posedge clk); #1;
        bus.htrans = 2'b00; bus.pready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        plan_clear();
        plan_xfer(2'b10, 1'b1, 1'b0, 32'h8400_0010, 32'h0, 32'h55AA_55AA, 0, 2);
        run_plan(plan_len);
        chk("lit_post_rst_psel", 1, 32'(ob_psel[1]), 32'b010);
        chk("lit_post_rst_hrdata", 2, ob_hrdata[2], 32'h55AA_55AA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
